// File: rtl/arith_pkg.sv
// Shared encodings for the arithmetic sequencer: operation select and FSM states.
package arith_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    MUL,
    DIV,
    DIV_FIX,
    DONE
  } state_t;

endpackage

// File: rtl/addsub_unit.sv
// Combinational W-bit adder/subtractor: s = x + (y ^ sub) + sub, with carry-out and
// signed overflow taken from the carries around the MSB.
module addsub_unit #(
  parameter int W = 33
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         ovf
);

  logic [W-1:0] yx;
  logic         c_msb;

  assign yx = y ^ {W{sub}};
  assign {c_msb, s[W-2:0]} = {1'b0, x[W-2:0]} + {1'b0, yx[W-2:0]} + {{(W-1){1'b0}}, sub};
  assign {cout, s[W-1]}    = {1'b0, x[W-1]} + {1'b0, yx[W-1]} + {1'b0, c_msb};
  assign ovf               = c_msb ^ cout;

endmodule

// File: rtl/arith_sequencer.sv
// Multi-cycle add/sub, Booth signed multiply and non-restoring unsigned divide,
// all time-sharing one WIDTH+1-bit adder under a small FSM.
module arith_sequencer
  import arith_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             ovf,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb;
  logic             sub_r;
  logic [WIDTH:0]   acc;          // Booth A or divider R
  logic [WIDTH-1:0] qr;           // multiplier / quotient shift register
  logic             q1;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   add_x, add_y, add_s, booth_a, div_fix;
  logic             add_sub, add_ovf, add_cout_unused;

  addsub_unit #(.W(WIDTH + 1)) u_addsub (
    .x   (add_x),
    .y   (add_y),
    .sub (add_sub),
    .s   (add_s),
    .cout(add_cout_unused),
    .ovf (add_ovf)
  );

  // In ADD the operands ride one bit up so the unit's MSB overflow is the
  // WIDTH-bit signed overflow; bit 0 absorbs the subtract carry-in.
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_sub = 1'b0;
    case (state)
      ADD: begin
        add_x   = {opa, 1'b0};
        add_y   = {opb, 1'b0};
        add_sub = sub_r;
      end
      MUL: begin
        add_x   = acc;
        add_y   = {opa[WIDTH-1], opa};
        add_sub = qr[0];
      end
      DIV: begin
        add_x   = {acc[WIDTH-1:0], qr[WIDTH-1]};
        add_y   = {1'b0, opb};
        add_sub = ~acc[WIDTH];
      end
      DIV_FIX: begin
        add_x   = acc;
        add_y   = {1'b0, opb};
      end
      default: ;
    endcase
  end

  assign booth_a = (qr[0] ^ q1) ? add_s : acc;
  assign div_fix = acc[WIDTH] ? add_s : acc;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (start) begin
          case (op)
            OP_MUL:  state_nxt = MUL;
            OP_DIV:  state_nxt = (b == '0) ? DONE : DIV;
            default: state_nxt = ADD;
          endcase
        end
      ADD:     state_nxt = DONE;
      MUL:     if (cnt == '0) state_nxt = DONE;
      DIV:     if (cnt == '0) state_nxt = DIV_FIX;
      DIV_FIX: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa       <= '0;
      opb       <= '0;
      sub_r     <= 1'b0;
      acc       <= '0;
      qr        <= '0;
      q1        <= 1'b0;
      cnt       <= '0;
      result_hi <= '0;
      result_lo <= '0;
      ovf       <= 1'b0;
      dbz       <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (start) begin
            opa   <= a;
            opb   <= b;
            sub_r <= (op == OP_SUB);
            acc   <= '0;
            qr    <= (op == OP_DIV) ? a : b;
            q1    <= 1'b0;
            cnt   <= CW'(WIDTH);
            ovf   <= 1'b0;
            dbz   <= 1'b0;
            if (op == OP_DIV && b == '0) begin
              result_lo <= '1;
              result_hi <= a;
              dbz       <= 1'b1;
            end
          end
        ADD: begin
          result_lo <= add_s[WIDTH:1];
          result_hi <= {WIDTH{add_s[WIDTH]}};
          ovf       <= add_ovf;
        end
        MUL:
          if (cnt != '0) begin
            {acc, qr, q1} <= {booth_a[WIDTH], booth_a, qr};
            cnt           <= cnt - CW'(1);
          end else begin
            result_hi <= acc[WIDTH-1:0];
            result_lo <= qr;
          end
        DIV:
          if (cnt != '0) begin
            acc <= add_s;
            qr  <= {qr[WIDTH-2:0], ~add_s[WIDTH]};
            cnt <= cnt - CW'(1);
          end
        DIV_FIX: begin
          acc       <= div_fix;
          result_hi <= div_fix[WIDTH-1:0];
          result_lo <= qr;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
